rr_mux_arbiter4: RTL

RR_MUX_ARBITER4 -- requirements
Module: rr_mux_arbiter4

---
 rtl/rr_mux_arbiter4_pkg.sv | 13 +
 rtl/mux4.sv | 24 ++
 rtl/rr_mux_arbiter4_pick.sv | 28 ++
 rtl/rr_mux_arbiter4.sv | 119 +++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin burst arbiter.
// The arbiter, its priority picker and its data mux all import this package.
package rr_mux_arbiter4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

endpackage

// File: rtl/mux4.sv
// Generic four-input data multiplexer used for steering requester data.
// The two-bit select picks which of the four inputs appears on the output.
module Mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter4_pick.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching upward from rr_ptr, wrapping modulo four.
module rr_pick4
  import rr_mux_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = rr_ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter4.sv
// Four-requester round-robin burst arbiter with a registered grant, a
// per-grant beat cap, and a one-cycle abort pulse for abandoned bursts.
module rr_mux_arbiter4
  import rr_mux_arbiter4_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [3:0]           last,
  input  logic [4*WIDTH-1:0]   data_in,
  output logic [3:0]           in_ready,
  output logic [3:0]           grant,
  output logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 abort
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               abort_q, abort_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick4 u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  Mux4 #(.WIDTH(WIDTH)) u_mux (
    .in0 (data_in[0*WIDTH +: WIDTH]),
    .in1 (data_in[1*WIDTH +: WIDTH]),
    .in2 (data_in[2*WIDTH +: WIDTH]),
    .in3 (data_in[3*WIDTH +: WIDTH]),
    .sel (sel_q),
    .out (out_data)
  );

  always_comb begin
    out_valid = (state_q == BUSY) && req[sel_q];
    out_last  = out_valid && (last[sel_q] || (cnt_q == LAST_CNT));
    in_ready  = grant_q & {NUM_REQ{out_ready}};
  end

  // A dropped request takes priority over any beat handshake on the same cycle.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          grant_d = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!req[sel_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = sel_q + 2'd1;
          cnt_d    = '0;
          abort_d  = 1'b1;
        end else if (out_ready) begin
          if (out_last) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = sel_q + 2'd1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign abort = abort_q;

endmodule
